// File: rtl/mux_2x1_pkg.sv
// rtl/mux_2x1_pkg.sv - shared widths and types for the 2:1 data selector
package mux_2x1_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;
  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mux_2x1_toggle_cnt.sv
// rtl/mux_2x1_toggle_cnt.sv - registered select and saturating select-change counter
module mux_2x1_toggle_cnt
  import mux_2x1_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             sel,
  output logic             sel_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  // sel_q clears to 0 on reset, so a high sel at release counts as a change.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sel_q      <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      sel_q <= sel;
      if ((sel != sel_q) && (toggle_cnt != {CNT_W{1'b1}})) begin
        toggle_cnt <= toggle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - 2:1 data selector with registered side-channel; MUX_2X1_OUT_REG_EN registers out
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] mux_c;

  // An if on an unknown sel falls to the else branch, so X/Z picks i0.
  always_comb begin
    if (sel) begin
      mux_c = i1;
    end else begin
      mux_c = i0;
    end
  end

`ifdef MUX_2X1_OUT_REG_EN
  logic [WIDTH-1:0] out_r;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_r <= '0;
    end else begin
      out_r <= mux_c;
    end
  end

  assign out = out_r;
`else
  assign out = mux_c;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

  mux_2x1_toggle_cnt #(
    .CNT_W(CNT_W)
  ) u_toggle_cnt (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .sel       (sel),
    .sel_q     (sel_q),
    .toggle_cnt(toggle_cnt)
  );

endmodule

// File: tb/tb_mux_2x1.sv
// tb/tb_mux_2x1.sv - directed self-checking bench for mux_2x1
module tb_mux_2x1;

  logic        CLOCK_50;
  logic        reset;
  logic [31:0] i0;
  logic [31:0] i1;
  logic        sel;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        sel_q;
  logic [15:0] toggle_cnt;

  int checks;
  int failures;

  mux_2x1 dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .i0        (i0),
    .i1        (i1),
    .sel       (sel),
    .out       (out),
    .out_q     (out_q),
    .sel_q     (sel_q),
    .toggle_cnt(toggle_cnt)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic edge_then_settle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_x_sel();
    i0 = 32'd100;
    i1 = 32'd2;
    #1;
    checks++;
    if (out !== 32'd100) begin
      failures++;
      $display("FAIL x_sel_out actual=%0d required=100", out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge CLOCK_50);
    sel = 1'b1;
    #1;
    checks++;
    if (out !== 32'd2) begin
      failures++;
      $display("FAIL reset_out_follows actual=%0d required=2", out);
    end
    for (int k = 0; k < 2; k++) begin
      edge_then_settle();
      checks++;
      if (out_q !== 32'd0) begin
        failures++;
        $display("FAIL reset_out_q cyc=%0d actual=%0h required=0", k, out_q);
      end
      checks++;
      if (sel_q !== 1'b0) begin
        failures++;
        $display("FAIL reset_sel_q cyc=%0d actual=%0b required=0", k, sel_q);
      end
      checks++;
      if (toggle_cnt !== 16'd0) begin
        failures++;
        $display("FAIL reset_cnt cyc=%0d actual=%0d required=0", k, toggle_cnt);
      end
      @(negedge CLOCK_50);
      sel = ~sel;
    end
    #1;
    checks++;
    if (out !== 32'd2) begin
      failures++;
      $display("FAIL reset_out_sel1 actual=%0d required=2", out);
    end
  endtask

  task automatic test_select();
    // sel is 1 at release: first edge sees sel_q=0 and counts one toggle
    reset = 1'b0;
    #1;
    edge_then_settle();
    checks++;
    if (out_q !== 32'd2) begin
      failures++;
      $display("FAIL sel1_out_q actual=%0d required=2", out_q);
    end
    checks++;
    if (sel_q !== 1'b1) begin
      failures++;
      $display("FAIL sel1_sel_q actual=%0b required=1", sel_q);
    end
    checks++;
    if (toggle_cnt !== 16'd1) begin
      failures++;
      $display("FAIL sel1_cnt actual=%0d required=1", toggle_cnt);
    end
    @(negedge CLOCK_50);
    sel = 1'b0;
    #1;
    checks++;
    if (out !== 32'd100) begin
      failures++;
      $display("FAIL sel0_out actual=%0d required=100", out);
    end
    checks++;
    if (out_q !== 32'd2) begin
      failures++;
      $display("FAIL sel0_out_q_before_edge actual=%0d required=2", out_q);
    end
    edge_then_settle();
    checks++;
    if (out_q !== 32'd100) begin
      failures++;
      $display("FAIL sel0_out_q actual=%0d required=100", out_q);
    end
    checks++;
    if (toggle_cnt !== 16'd2) begin
      failures++;
      $display("FAIL sel0_cnt actual=%0d required=2", toggle_cnt);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge CLOCK_50);
    sel = 1'b1;
    i1  = 32'hA5A5_0F0F;
    i0  = 32'h1234_5678;
    #1;
    checks++;
    if (out !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL simul_out actual=%0h required=a5a50f0f", out);
    end
    edge_then_settle();
    checks++;
    if (out_q !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL simul_out_q actual=%0h required=a5a50f0f", out_q);
    end
    checks++;
    if (toggle_cnt !== 16'd3) begin
      failures++;
      $display("FAIL simul_cnt actual=%0d required=3", toggle_cnt);
    end
    @(negedge CLOCK_50);
    i1 = 32'hFFFF_0000;
    edge_then_settle();
    checks++;
    if (toggle_cnt !== 16'd3) begin
      failures++;
      $display("FAIL hold_cnt actual=%0d required=3", toggle_cnt);
    end
    checks++;
    if (out_q !== 32'hFFFF_0000) begin
      failures++;
      $display("FAIL hold_out_q actual=%0h required=ffff0000", out_q);
    end
  endtask

  task automatic test_saturation();
    @(negedge CLOCK_50);
    reset = 1'b1;
    sel   = 1'b0;
    edge_then_settle();
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int k = 1; k <= 65541; k++) begin
      @(negedge CLOCK_50);
      sel = ~sel;
      edge_then_settle();
      if (k == 100 || k == 65534 || k == 65535 || k == 65541) begin
        checks++;
        if (toggle_cnt !== ((k >= 65535) ? 16'hFFFF : 16'(k))) begin
          failures++;
          $display("FAIL sat_cnt k=%0d actual=%0h", k, toggle_cnt);
        end
      end
    end
    // reset mid-operation has no effect until the next edge
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    checks++;
    if (toggle_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sync_reset_cnt_before_edge actual=%0h required=ffff", toggle_cnt);
    end
    edge_then_settle();
    checks++;
    if (toggle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL sync_reset_cnt_after_edge actual=%0h required=0", toggle_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_out_reg();
    @(negedge CLOCK_50);
    reset = 1'b1;
    i0    = 32'hDEAD_BEEF;
    i1    = 32'd0;
    sel   = 1'b0;
    edge_then_settle();
    checks++;
    if (out !== 32'd0) begin
      failures++;
      $display("FAIL outreg_reset_out actual=%0h required=0", out);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 32'd0) begin
      failures++;
      $display("FAIL outreg_before_edge actual=%0h required=0", out);
    end
    edge_then_settle();
    checks++;
    if (out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL outreg_out actual=%0h required=deadbeef", out);
    end
    checks++;
    if (out_q !== 32'd0) begin
      failures++;
      $display("FAIL outreg_out_q_stage1 actual=%0h required=0", out_q);
    end
    edge_then_settle();
    checks++;
    if (out_q !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL outreg_out_q_stage2 actual=%0h required=deadbeef", out_q);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
`ifdef MUX_2X1_OUT_REG_EN
    sel = 1'b0;
    i0  = 32'd0;
    i1  = 32'd0;
    test_out_reg();
`else
    test_x_sel();
    test_reset();
    test_select();
    test_simultaneous();
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
